soc_uart: RTL

- Parametrised UART for the mips32r1 SoC: serial console and nmon monitor link, plus a host-side transactor in the SoC bench.
- TX path: FIFO in front of a frame serialiser. RX path: 2-flop synchroniser, mid-bit sampler and FIFO.
- Generalises the fixed 10 MHz / 9600 console. Clock rate, baud, data width, parity, stop bits and FIFO depth are parameters.
- Adds error reporting: framing, parity and overrun.

---
 rtl/soc_uart.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/soc_uart.sv
// soc_uart: parametrised UART with TX/RX FIFOs, a frame serialiser,
// a synchronised mid-bit receiver and sticky framing/parity/overrun flags.
module soc_uart #(
    parameter int CLK_FREQ_HZ = 10000000,
    parameter int BAUD        = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_idle,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    input  logic                 err_clear,
    output logic                 uart_txd,
    input  logic                 uart_rxd
);
    localparam int DIV  = CLK_FREQ_HZ / BAUD;
    localparam int CW   = $clog2(DIV);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CW-1:0]   BIT_LOAD  = CW'(DIV - 1);
    localparam logic [CW-1:0]   HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CNTW-1:0] FULL      = CNTW'(FIFO_DEPTH);
    localparam logic [2:0]      LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic            PAR_ODD   = (PARITY == 1);
    localparam logic            STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        tx_wr_ptr, tx_rd_ptr;
    logic [CNTW-1:0]      tx_count;
    logic                 tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_ready = (tx_count != FULL);
    assign tx_push  = tx_valid & tx_ready;
    assign tx_head  = tx_mem[tx_rd_ptr];

    // TX FIFO storage; contents need no reset because the count gates every read
    always_ff @(posedge clock) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
            tx_count <= tx_count + CNTW'(tx_push) - CNTW'(tx_pop);
        end
    end

    // ---------------- TX serialiser ----------------
    state_t               tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [2:0]           tx_bit;
    logic                 tx_stop_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_level;

    assign tx_idle = (tx_state == S_IDLE) && (tx_count == '0);

    // Fetch the next byte when idle, or at the end of the last stop bit for back-to-back frames
    always_comb begin
        tx_pop = 1'b0;
        if (tx_count != '0) begin
            if (tx_state == S_IDLE)
                tx_pop = 1'b1;
            else if (tx_state == S_STOP && tx_cnt == '0 && tx_stop_idx == STOP_LAST)
                tx_pop = 1'b1;
        end
    end

    // Line level belonging to the current serialiser state
    always_comb begin
        tx_level = 1'b1;
        case (tx_state)
            S_START:  tx_level = 1'b0;
            S_DATA:   tx_level = tx_shift[0];
            S_PARITY: tx_level = tx_par;
            default:  tx_level = 1'b1;
        endcase
    end

    // TX frame state machine; uart_txd is registered so it trails the state by one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state    <= S_IDLE;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_stop_idx <= 1'b0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
            uart_txd    <= 1'b1;
        end else begin
            uart_txd <= tx_level;
            if (tx_pop) begin
                tx_shift <= tx_head;
                tx_par   <= (^tx_head) ^ PAR_ODD;
            end
            case (tx_state)
                S_IDLE: begin
                    if (tx_pop) begin
                        tx_state <= S_START;
                        tx_cnt   <= BIT_LOAD;
                    end
                end
                S_START: begin
                    if (tx_cnt == '0) begin
                        tx_state <= S_DATA;
                        tx_cnt   <= BIT_LOAD;
                        tx_bit   <= '0;
                    end else tx_cnt <= tx_cnt - CW'(1);
                end
                S_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt   <= BIT_LOAD;
                        tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
                        if (tx_bit == LAST_BIT) begin
                            tx_state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                            tx_stop_idx <= 1'b0;
                        end else tx_bit <= tx_bit + 3'd1;
                    end else tx_cnt <= tx_cnt - CW'(1);
                end
                S_PARITY: begin
                    if (tx_cnt == '0) begin
                        tx_state    <= S_STOP;
                        tx_cnt      <= BIT_LOAD;
                        tx_stop_idx <= 1'b0;
                    end else tx_cnt <= tx_cnt - CW'(1);
                end
                S_STOP: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= BIT_LOAD;
                        if (tx_stop_idx != STOP_LAST) tx_stop_idx <= 1'b1;
                        else if (tx_pop)              tx_state <= S_START;
                        else                          tx_state <= S_IDLE;
                    end else tx_cnt <= tx_cnt - CW'(1);
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX path ----------------
    logic rx_meta, rxs, rxs_prev;

    // Two-flop synchroniser for the asynchronous line plus one delayed copy for edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= uart_rxd;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    state_t               rx_state;
    logic [CW-1:0]        rx_cnt;
    logic [2:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par;
    logic                 rx_break;
    logic                 stop_sample, par_bad, rx_good, rx_push, rx_pop;

    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        rx_wr_ptr, rx_rd_ptr;
    logic [CNTW-1:0]      rx_count;

    assign rx_valid    = (rx_count != '0);
    assign rx_data     = rx_valid ? rx_mem[rx_rd_ptr] : '0;
    assign rx_pop      = rx_valid & rx_ready;
    assign stop_sample = (rx_state == S_STOP) && !rx_break && (rx_cnt == '0);
    assign par_bad     = (PARITY != 0) && (((^rx_shift) ^ rx_par) != PAR_ODD);
    assign rx_good     = stop_sample && rxs && !par_bad;
    assign rx_push     = rx_good && ((rx_count != FULL) || rx_pop);

    // RX frame state machine with sticky error flags; a new error outranks err_clear
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state      <= S_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            rx_par        <= 1'b0;
            rx_break      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            if (err_clear) begin
                rx_frame_err  <= 1'b0;
                rx_parity_err <= 1'b0;
                rx_overrun    <= 1'b0;
            end
            case (rx_state)
                S_IDLE: begin
                    if (rxs_prev && !rxs) begin
                        rx_state <= S_START;
                        rx_cnt   <= HALF_LOAD;
                    end
                end
                S_START: begin
                    if (rx_cnt == '0) begin
                        if (!rxs) begin
                            rx_state <= S_DATA;
                            rx_cnt   <= BIT_LOAD;
                            rx_bit   <= '0;
                        end else rx_state <= S_IDLE;
                    end else rx_cnt <= rx_cnt - CW'(1);
                end
                S_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_cnt   <= BIT_LOAD;
                        rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == LAST_BIT) rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        else                    rx_bit <= rx_bit + 3'd1;
                    end else rx_cnt <= rx_cnt - CW'(1);
                end
                S_PARITY: begin
                    if (rx_cnt == '0) begin
                        rx_par   <= rxs;
                        rx_state <= S_STOP;
                        rx_cnt   <= BIT_LOAD;
                    end else rx_cnt <= rx_cnt - CW'(1);
                end
                S_STOP: begin
                    if (rx_break) begin
                        if (rxs) begin
                            rx_break <= 1'b0;
                            rx_state <= S_IDLE;
                        end
                    end else if (rx_cnt == '0) begin
                        if (!rxs) begin
                            rx_frame_err <= 1'b1;
                            rx_break     <= 1'b1;
                        end else begin
                            if (par_bad)       rx_parity_err <= 1'b1;
                            else if (!rx_push) rx_overrun    <= 1'b1;
                            rx_state <= S_IDLE;
                        end
                    end else rx_cnt <= rx_cnt - CW'(1);
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // RX FIFO storage
    always_ff @(posedge clock) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_shift;
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
            rx_count <= rx_count + CNTW'(rx_push) - CNTW'(rx_pop);
        end
    end
endmodule
